// File: rtl/dev_bus_arbiter.sv
// dev_bus_arbiter: two-master per-transaction arbiter for the shared devctrl bus.
// Optional transaction watchdog enabled by defining ARB_TIMEOUT_EN.
module dev_bus_arbiter #(
  parameter bit          FIXED_PRIO     = 1'b0,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_enable_i,
  input  logic        m1_enable_i,
  input  logic        m0_write_i,
  input  logic        m1_write_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m0_dataSave_i,
  input  logic [31:0] m1_dataSave_i,
  input  logic [3:0]  m0_byteSelect_i,
  input  logic [3:0]  m1_byteSelect_i,
  output logic [31:0] m0_dataLoad_o,
  output logic [31:0] m1_dataLoad_o,
  output logic        m0_busy_o,
  output logic        m1_busy_o,
  output logic        devEnable_o,
  output logic        devWrite_o,
  output logic [31:0] devPhysicalAddr_o,
  output logic [31:0] devDataSave_o,
  output logic [3:0]  devByteSelect_o,
  input  logic [31:0] devDataLoad_i,
  input  logic        devBusy_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state;
  logic last;
  logic own0, own1, en, done, tmo, pick1;
  assign own0 = state == OWN0;
  assign own1 = state == OWN1;
  assign en = own0 ? m0_enable_i : own1 & m1_enable_i;
  assign done = en & ~devBusy_i;
`ifdef ARB_TIMEOUT_EN
  logic [15:0] cnt;
  assign tmo = en & devBusy_i & (cnt == TIMEOUT_CYCLES - 16'd1);
`else
  logic unused_tc;
  assign unused_tc = ^TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif
  // on a tie in round-robin mode, the master that did not own the bus last wins
  assign pick1 = m1_enable_i & (~m0_enable_i | (~FIXED_PRIO & ~last));
  assign devEnable_o = en & ~tmo;
  assign devWrite_o = own0 ? m0_write_i : own1 & m1_write_i;
  assign devPhysicalAddr_o = own0 ? m0_addr_i : own1 ? m1_addr_i : '0;
  assign devDataSave_o = own0 ? m0_dataSave_i : own1 ? m1_dataSave_i : '0;
  assign devByteSelect_o = own0 ? m0_byteSelect_i : own1 ? m1_byteSelect_i : '0;
  assign m0_busy_o = own0 ? m0_enable_i & devBusy_i & ~tmo : m0_enable_i;
  assign m1_busy_o = own1 ? m1_enable_i & devBusy_i & ~tmo : m1_enable_i;
  assign m0_dataLoad_o = own0 & done ? devDataLoad_i : own0 & tmo ? 32'hDEADBEEF : '0;
  assign m1_dataLoad_o = own1 & done ? devDataLoad_i : own1 & tmo ? 32'hDEADBEEF : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last <= 1'b1;
      grant_o <= 2'b00;
      timeout_o <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt <= '0;
`endif
    end else begin
      timeout_o <= tmo;
      if (state == IDLE) begin
`ifdef ARB_TIMEOUT_EN
        cnt <= '0;
`endif
        if (m0_enable_i | m1_enable_i) begin
          state <= pick1 ? OWN1 : OWN0;
          grant_o <= pick1 ? 2'b10 : 2'b01;
        end
      end else if (~en | ~devBusy_i | tmo) begin
        state <= IDLE;
        last <= own1;
        grant_o <= 2'b00;
      end
`ifdef ARB_TIMEOUT_EN
      else cnt <= cnt + 16'd1;
`endif
    end
  end
endmodule

// File: tb/tb_dev_bus_arbiter.sv
// tb_dev_bus_arbiter: directed checks of dev_bus_arbiter in round-robin (a) and fixed-priority (b) builds.
module tb_dev_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m0_en = 0, m1_en = 0, m0_wr = 0, m1_wr = 0, dev_busy = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0, m0_ds = 0, m1_ds = 0, dev_dl = 0;
  logic [3:0] m0_bs = 0, m1_bs = 0;
  logic [31:0] a_m0_dl, a_m1_dl, a_addr, a_ds, b_m0_dl, b_m1_dl, b_addr, b_ds;
  logic a_m0_busy, a_m1_busy, a_en, a_wr, a_tmo, b_m0_busy, b_m1_busy, b_en, b_wr, b_tmo;
  logic [3:0] a_bs, b_bs;
  logic [1:0] a_grant, b_grant;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  dev_bus_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT_CYCLES(16'd8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .m0_enable_i(m0_en), .m1_enable_i(m1_en), .m0_write_i(m0_wr), .m1_write_i(m1_wr),
    .m0_addr_i(m0_addr), .m1_addr_i(m1_addr), .m0_dataSave_i(m0_ds), .m1_dataSave_i(m1_ds),
    .m0_byteSelect_i(m0_bs), .m1_byteSelect_i(m1_bs),
    .m0_dataLoad_o(a_m0_dl), .m1_dataLoad_o(a_m1_dl), .m0_busy_o(a_m0_busy), .m1_busy_o(a_m1_busy),
    .devEnable_o(a_en), .devWrite_o(a_wr), .devPhysicalAddr_o(a_addr), .devDataSave_o(a_ds),
    .devByteSelect_o(a_bs), .devDataLoad_i(dev_dl), .devBusy_i(dev_busy),
    .grant_o(a_grant), .timeout_o(a_tmo));

  dev_bus_arbiter #(.FIXED_PRIO(1'b1), .TIMEOUT_CYCLES(16'd8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .m0_enable_i(m0_en), .m1_enable_i(m1_en), .m0_write_i(m0_wr), .m1_write_i(m1_wr),
    .m0_addr_i(m0_addr), .m1_addr_i(m1_addr), .m0_dataSave_i(m0_ds), .m1_dataSave_i(m1_ds),
    .m0_byteSelect_i(m0_bs), .m1_byteSelect_i(m1_bs),
    .m0_dataLoad_o(b_m0_dl), .m1_dataLoad_o(b_m1_dl), .m0_busy_o(b_m0_busy), .m1_busy_o(b_m1_busy),
    .devEnable_o(b_en), .devWrite_o(b_wr), .devPhysicalAddr_o(b_addr), .devDataSave_o(b_ds),
    .devByteSelect_o(b_bs), .devDataLoad_i(dev_dl), .devBusy_i(dev_busy),
    .grant_o(b_grant), .timeout_o(b_tmo));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m0_en = 1'b1;
    m0_addr = 32'h5555_0000;
    #3;
    checks++;
    if (a_grant !== 2'b00 || b_grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b/%b exp=00", a_grant, b_grant); end
    checks++;
    if (a_en !== 1'b0 || a_addr !== 32'h0 || a_tmo !== 1'b0) begin failures++; $display("FAIL reset_dev got en=%b addr=%h tmo=%b exp 0", a_en, a_addr, a_tmo); end
    checks++;
    if (a_m0_busy !== 1'b1 || a_m1_busy !== 1'b0 || a_m0_dl !== 32'h0) begin failures++; $display("FAIL reset_busy got=%b%b dl=%h exp=10 dl=0", a_m0_busy, a_m1_busy, a_m0_dl); end
    tick();
    tick();
    m0_en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int n0 = 0, n1 = 0;
    tick();
    m0_en = 1; m1_en = 1; dev_busy = 0;
    m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200;
    @(negedge clk);
    checks++;
    if (a_grant !== 2'b00) begin failures++; $display("FAIL rr_first_idle got=%b exp=00", a_grant); end
    for (int k = 0; k < 8; k++) begin
      logic [1:0] eg;
      logic [31:0] ea;
      tick();
      dev_dl = 32'hA000_0000 | k;
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      ea = (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
      @(negedge clk);
      checks++;
      if (a_grant !== eg || a_addr !== ea) begin failures++; $display("FAIL rr_own%0d got grant=%b addr=%h exp grant=%b addr=%h", k, a_grant, a_addr, eg, ea); end
      checks++;
      if (eg == 2'b01 && (a_m0_busy !== 1'b0 || a_m0_dl !== dev_dl || a_m1_busy !== m1_en || a_m1_dl !== 32'h0)) begin
        failures++; $display("FAIL rr_resp%0d got m0 busy=%b dl=%h m1 busy=%b dl=%h", k, a_m0_busy, a_m0_dl, a_m1_busy, a_m1_dl);
      end
      if (eg == 2'b10 && (a_m1_busy !== 1'b0 || a_m1_dl !== dev_dl || a_m0_busy !== m0_en || a_m0_dl !== 32'h0)) begin
        failures++; $display("FAIL rr_resp%0d got m1 busy=%b dl=%h m0 busy=%b dl=%h", k, a_m1_busy, a_m1_dl, a_m0_busy, a_m0_dl);
      end
      if (eg == 2'b01) n0++; else n1++;
      tick();
      if (n0 == 4) m0_en = 0;
      if (n1 == 4) m1_en = 0;
      @(negedge clk);
      checks++;
      if (a_grant !== 2'b00 || a_en !== 1'b0) begin failures++; $display("FAIL rr_idle%0d got grant=%b en=%b exp 00/0", k, a_grant, a_en); end
    end
    tick();
    tick();
  endtask

  task automatic test_fixed_prio();
    tick();
    m0_en = 1; m1_en = 1; dev_busy = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (b_grant !== ((k % 2 == 0) ? 2'b00 : 2'b01)) begin failures++; $display("FAIL fp_cyc%0d got=%b exp=%b", k, b_grant, (k % 2 == 0) ? 2'b00 : 2'b01); end
      tick();
    end
    m0_en = 0;
    @(negedge clk);
    checks++;
    if (b_grant !== 2'b00) begin failures++; $display("FAIL fp_idle got=%b exp=00", b_grant); end
    tick();
    @(negedge clk);
    checks++;
    if (b_grant !== 2'b10 || b_addr !== 32'h0000_0200) begin failures++; $display("FAIL fp_m1_grant got=%b addr=%h exp=10 addr=00000200", b_grant, b_addr); end
    tick();
    m1_en = 0;
    tick();
    tick();
  endtask

  task automatic test_store();
    tick();
    m0_addr = 32'hFFFF_0000; m0_ds = 32'h1111_1111; m0_bs = 4'b1111; m0_wr = 0;
    m1_en = 1; m1_wr = 1; m1_addr = 32'h1FD0_03F8; m1_ds = 32'h0000_00AA; m1_bs = 4'b0001;
    dev_busy = 1;
    @(negedge clk);
    checks++;
    if (a_en !== 1'b0 || a_wr !== 1'b0 || a_ds !== 32'h0) begin failures++; $display("FAIL st_idle got en=%b wr=%b ds=%h exp zeros", a_en, a_wr, a_ds); end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) dev_busy = 0;
      @(negedge clk);
      checks++;
      if (a_grant !== 2'b10 || a_en !== 1'b1 || a_wr !== 1'b1 || a_addr !== 32'h1FD0_03F8 || a_ds !== 32'h0000_00AA || a_bs !== 4'b0001) begin
        failures++; $display("FAIL st_own%0d got g=%b en=%b wr=%b addr=%h ds=%h bs=%b", k, a_grant, a_en, a_wr, a_addr, a_ds, a_bs);
      end
      checks++;
      if (a_m1_busy !== (k != 2)) begin failures++; $display("FAIL st_busy%0d got=%b exp=%b", k, a_m1_busy, k != 2); end
    end
    tick();
    m1_en = 0; m1_wr = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    tick();
    m0_en = 1; m0_addr = 32'h8000_0010; dev_busy = 1; dev_dl = 32'h0BAD_F00D;
    tick();
    @(negedge clk);
    checks++;
    if (a_grant !== 2'b01 || a_en !== 1'b1) begin failures++; $display("FAIL rm_own got grant=%b en=%b exp=01/1", a_grant, a_en); end
    #1 rst_n = 0;
    #1;
    checks++;
    if (a_en !== 1'b0 || a_grant !== 2'b00 || a_addr !== 32'h0) begin failures++; $display("FAIL rm_async got en=%b grant=%b addr=%h exp 0/00/0", a_en, a_grant, a_addr); end
    tick();
    rst_n = 1; dev_busy = 0;
    @(negedge clk);
    checks++;
    if (a_grant !== 2'b00) begin failures++; $display("FAIL rm_post_idle got=%b exp=00", a_grant); end
    tick();
    @(negedge clk);
    checks++;
    if (a_grant !== 2'b01 || a_m0_busy !== 1'b0 || a_m0_dl !== 32'h0BAD_F00D) begin failures++; $display("FAIL rm_regrant got grant=%b busy=%b dl=%h exp 01/0/0badf00d", a_grant, a_m0_busy, a_m0_dl); end
    tick();
    m0_en = 0;
    tick();
  endtask

  task automatic test_single_load();
    tick();
    m0_en = 1; m0_wr = 0; m0_addr = 32'h8000_0010; dev_busy = 1; dev_dl = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (a_grant !== 2'b00 || a_m0_busy !== 1'b1 || a_en !== 1'b0) begin failures++; $display("FAIL ld_req got grant=%b busy=%b en=%b", a_grant, a_m0_busy, a_en); end
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if (a_grant !== 2'b01 || a_en !== 1'b1 || a_addr !== 32'h8000_0010 || a_m0_busy !== 1'b1 || a_m0_dl !== 32'h0) begin
        failures++; $display("FAIL ld_wait%0d got grant=%b en=%b addr=%h busy=%b dl=%h", k, a_grant, a_en, a_addr, a_m0_busy, a_m0_dl);
      end
    end
    tick();
    dev_busy = 0;
    @(negedge clk);
    checks++;
    if (a_m0_busy !== 1'b0 || a_m0_dl !== 32'h1234_5678) begin failures++; $display("FAIL ld_done got busy=%b dl=%h exp 0/12345678", a_m0_busy, a_m0_dl); end
    tick();
    m0_en = 0;
    @(negedge clk);
    checks++;
    if (a_grant !== 2'b00 || a_en !== 1'b0) begin failures++; $display("FAIL ld_after got grant=%b en=%b exp 00/0", a_grant, a_en); end
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    tick();
    m0_en = 1; m0_addr = 32'h8000_0020; dev_busy = 1; dev_dl = 32'h7777_7777;
    tick();
    m1_en = 1; m1_addr = 32'h0000_0300;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (k < 8 && (a_grant !== 2'b01 || a_m0_busy !== 1'b1 || a_en !== 1'b1 || a_tmo !== 1'b0)) begin
        failures++; $display("FAIL to_wait%0d got grant=%b busy=%b en=%b tmo=%b", k, a_grant, a_m0_busy, a_en, a_tmo);
      end
      if (k == 8 && (a_m0_busy !== 1'b0 || a_m0_dl !== 32'hDEAD_BEEF || a_en !== 1'b0)) begin
        failures++; $display("FAIL to_force got busy=%b dl=%h en=%b exp 0/deadbeef/0", a_m0_busy, a_m0_dl, a_en);
      end
      tick();
    end
    m0_en = 0;
    @(negedge clk);
    checks++;
    if (a_tmo !== 1'b1 || a_grant !== 2'b00) begin failures++; $display("FAIL to_pulse got tmo=%b grant=%b exp 1/00", a_tmo, a_grant); end
    tick();
    dev_busy = 0;
    @(negedge clk);
    checks++;
    if (a_tmo !== 1'b0 || a_grant !== 2'b10 || a_m1_busy !== 1'b0) begin failures++; $display("FAIL to_next got tmo=%b grant=%b busy=%b exp 0/10/0", a_tmo, a_grant, a_m1_busy); end
    tick();
    m1_en = 0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_prio();
    test_store();
    test_single_load();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dev_bus_arbiter.md
Name: dev_bus_arbiter

Overview:
- Two-master arbiter for the single shared device bus that feeds devctrl. Master 0 is the CPU and master 1 is a DMA-capable peripheral engine (Ethernet/USB copy engine).
- Grants the bus per transaction, using round-robin or fixed priority.
- Forwards the owner's request to devctrl and routes busy/load data back to that owner only.
- Sits between the cpu and devctrl instances, in the clkMain domain.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin; 1 = master 0 always wins simultaneous requests.
- TIMEOUT_CYCLES, 1024: watchdog limit per granted transaction. Used only with ARB_TIMEOUT_EN. Width is 16 bits; legal range is 2..65535.

Ports:
- clk  in  1  clkMain
- rst_n  in  1  asynchronous active-low reset
- m0_enable_i, m1_enable_i  in  1  request; held high until own busy_o low
- m0_write_i, m1_write_i  in  1  1 = store
- m0_addr_i, m1_addr_i  in  32  physical address
- m0_dataSave_i, m1_dataSave_i  in  32  store data
- m0_byteSelect_i, m1_byteSelect_i  in  4  byte lanes
- m0_dataLoad_o, m1_dataLoad_o  out  32  load data
- m0_busy_o, m1_busy_o  out  1  transaction not yet complete
- devEnable_o  out  1  to devctrl
- devWrite_o  out  1  to devctrl
- devPhysicalAddr_o  out  32  to devctrl
- devDataSave_o  out  32  to devctrl
- devByteSelect_o  out  4  to devctrl
- devDataLoad_i  in  32  from devctrl
- devBusy_i  in  1  from devctrl
- grant_o  out  2  one-hot owner (bit0 = m0, bit1 = m1); 00 = idle
- timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- States: IDLE, OWN0, OWN1. Reset forces IDLE asynchronously. In reset:
  - grant_o = 00, last-owner pointer = 1 (so m0 wins first), timeout_o = 0, watchdog count = 0.
  - All dev*_o = 0; mN_busy_o follows mN_enable_i; mN_dataLoad_o = 0.
- IDLE:
  - No request: stay.
  - One request: go to that OWN.
  - Both requesting: FIXED_PRIO=1 → OWN0. FIXED_PRIO=0 → the master that was not the last owner.
  - Grant is registered, so there is 1 cycle of arbitration latency. dev*_o = 0 in IDLE.
- OWNn:
  - dev* outputs equal master n's inputs combinationally. devEnable_o = mn_enable_i.
- Completion cycle = OWNn and mn_enable_i=1 and devBusy_i=0. On that cycle:
  - mn_busy_o = 0 and mn_dataLoad_o = devDataLoad_i.
  - Next state is IDLE and last-owner := n.
  - Back-to-back requests therefore cost 1 idle cycle each. This gives the other master a fair slot.
- busy to masters:
  - Owner: mn_busy_o = mn_enable_i & devBusy_i.
  - Non-owner, or any master in IDLE: mX_busy_o = mX_enable_i.
  - Non-owner mX_dataLoad_o = 0.
- Cancel: owner deasserts enable before completion → devEnable_o drops the same cycle, next state IDLE, last-owner := n. This is a protocol violation, but the response is defined.
- Non-owner request inputs never reach the dev outputs; devctrl sees exactly one master at a time.
- Reset mid-transaction: devEnable_o drops immediately (async). Masters re-issue after reset.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entering OWNn and increments each OWNn cycle while devBusy_i=1.
  - At count == TIMEOUT_CYCLES-1 with devBusy_i still 1, the arbiter forces completion: mn_busy_o = 0, mn_dataLoad_o = 32'hDEADBEEF, devEnable_o = 0 that cycle.
  - timeout_o pulses for 1 cycle, next state IDLE, last-owner := n.
  - A normal completion on the same cycle takes precedence: no pulse, real data returned.
- Undefined: no counter; timeout_o tied 0; a hung device holds the bus indefinitely.

Test Plan:
- Single m0 load, addr=32'h80000010, devBusy_i high 3 cycles, devDataLoad_i=32'h12345678 → grant_o=01 on cycle after request; m0_busy_o low in completion cycle with m0_dataLoad_o=32'h12345678; grant_o=00 next cycle.
- Simultaneous m0/m1 requests out of reset, FIXED_PRIO=0, each held for 4 back-to-back transactions → grants alternate 01,10,01,10,...; m1 never sees dev outputs while grant_o=01.
- FIXED_PRIO=1, m0 and m1 requesting continuously → m1 never granted while m0_enable_i stays high; m1 granted in first IDLE with m0_enable_i=0.
- m1 store addr=32'h1FD003F8, data=32'h000000AA, byteSelect=4'b0001 while m0 idle → devWrite_o=1, devDataSave_o=32'h000000AA, devByteSelect_o=4'b0001 in OWN1 cycles.
- rst_n low mid-OWN0 with devBusy_i=1 → devEnable_o=0 and grant_o=00 without a clock edge; after release, m0 re-request granted normally.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, devBusy_i stuck 1 on m0 → m0_busy_o low on 8th OWN0 cycle with m0_dataLoad_o=32'hDEADBEEF; timeout_o=1 one cycle; pending m1 granted next.
